fsm_prog_loader: RTL



---
 rtl/fsm_prog_loader.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/fsm_prog_loader.sv
// fsm_prog_loader
// Upstream programming stage for the programmable FSM controller. While
// prog_enable is high it assembles 5-byte frames from data_in/data_valid:
// SYNC, ADDR = {state, input}, NEXT, OUT, CHK = ADDR ^ NEXT ^ OUT.
// Records that pass the checksum and range checks are written into the
// controller's table with a single-cycle wr_en strobe. The strobe is
// registered and appears one cycle after the CHK byte.
//
// Ports
//   clock        system clock, rising edge
//   rst          synchronous active-high reset
//   prog_enable  loader active when high
//   data_in      received byte
//   data_valid   single-cycle qualifier for data_in
//   wr_en        one-cycle table write strobe
//   wr_state     source-state field of the write address
//   wr_input     input-value field of the write address
//   wr_next      next-state value to store
//   wr_out       output byte to store
//   busy         frame in progress
//   err_chk      sticky checksum-mismatch flag
//   err_range    sticky out-of-range state flag
//   rec_count    accepted-record count (wraps)
//   err_timeout  sticky inter-byte timeout flag (FSM_LOADER_TIMEOUT_EN only)
//
// Optional feature macro: FSM_LOADER_TIMEOUT_EN. It adds an inter-byte gap
// timeout of TIMEOUT_CYCLES and the err_timeout port.

module fsm_prog_loader #(
  parameter int          STATE_COUNT    = 8,
  parameter int          STATE_WIDTH    = $clog2(STATE_COUNT),
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
  parameter int          TIMEOUT_CYCLES = 1023
) (
  input  logic                   clock,
  input  logic                   rst,
  input  logic                   prog_enable,
  input  logic [7:0]             data_in,
  input  logic                   data_valid,
  output logic                   wr_en,
  output logic [STATE_WIDTH-1:0] wr_state,
  output logic [3:0]             wr_input,
  output logic [STATE_WIDTH-1:0] wr_next,
  output logic [7:0]             wr_out,
  output logic                   busy,
  output logic                   err_chk,
  output logic                   err_range,
`ifdef FSM_LOADER_TIMEOUT_EN
  output logic                   err_timeout,
`endif
  output logic [7:0]             rec_count
);

  if (STATE_COUNT < 2 || STATE_COUNT > 16 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 1023) begin : g_param_check
    $error("fsm_prog_loader: STATE_COUNT must be 2..16 and TIMEOUT_CYCLES 1..1023");
  end

  typedef enum logic [2:0] {IDLE, GET_ADDR, GET_NEXT, GET_OUT, GET_CHK} state_t;

  localparam logic [4:0] STATE_LIMIT = 5'(STATE_COUNT);

  state_t     state, next_state;
  logic [7:0] addr_q;
  logic [3:0] next_q;
  logic [7:0] out_q;
  logic [7:0] chk_acc;
  logic       prev_enable;
  logic       enable_rise;
  logic       byte_take;
  logic       rec_ok, rec_chk_bad, rec_range_bad;
  logic       timeout_hit;

  assign byte_take   = prog_enable & data_valid;
  assign enable_rise = prog_enable & ~prev_enable;
  assign busy        = (state != IDLE);

`ifdef FSM_LOADER_TIMEOUT_EN
  localparam logic [9:0] GAP_LIMIT = 10'(TIMEOUT_CYCLES - 1);
  logic [9:0] gap_cnt;

  // The edge on which the counter would reach TIMEOUT_CYCLES is the edge
  // that drops the frame.
  assign timeout_hit = busy & prog_enable & ~data_valid & (gap_cnt == GAP_LIMIT);

  always_ff @(posedge clock) begin
    if (rst || !busy || byte_take) gap_cnt <= '0;
    else                           gap_cnt <= gap_cnt + 10'd1;
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state    = state;
    rec_ok        = 1'b0;
    rec_chk_bad   = 1'b0;
    rec_range_bad = 1'b0;
    if (!prog_enable) begin
      next_state = IDLE;
    end else if (timeout_hit) begin
      next_state = IDLE;
    end else if (data_valid) begin
      case (state)
        IDLE:     if (data_in == SYNC_BYTE) next_state = GET_ADDR;
        GET_ADDR: next_state = GET_NEXT;
        GET_NEXT: next_state = GET_OUT;
        GET_OUT:  next_state = GET_CHK;
        GET_CHK: begin
          next_state = IDLE;
          // NEXT is range checked on its full low nibble so values such as 9
          // are rejected even when STATE_WIDTH is narrower than 4 bits.
          if (data_in != chk_acc)
            rec_chk_bad = 1'b1;
          else if ({1'b0, addr_q[7:4]} >= STATE_LIMIT || {1'b0, next_q} >= STATE_LIMIT)
            rec_range_bad = 1'b1;
          else
            rec_ok = 1'b1;
        end
        default:  next_state = IDLE;
      endcase
    end
  end

  // Field capture and running checksum of ADDR ^ NEXT ^ OUT.
  always_ff @(posedge clock) begin
    if (rst) begin
      addr_q  <= '0;
      next_q  <= '0;
      out_q   <= '0;
      chk_acc <= '0;
    end else if (byte_take) begin
      case (state)
        GET_ADDR: begin addr_q <= data_in; chk_acc <= data_in;           end
        GET_NEXT: begin next_q <= data_in[3:0]; chk_acc <= chk_acc ^ data_in; end
        GET_OUT:  begin out_q  <= data_in; chk_acc <= chk_acc ^ data_in; end
        default:  ;
      endcase
    end
  end

  // Write port: strobe for one cycle, fields hold until the next accepted record.
  always_ff @(posedge clock) begin
    if (rst) begin
      wr_en    <= 1'b0;
      wr_state <= '0;
      wr_input <= '0;
      wr_next  <= '0;
      wr_out   <= '0;
    end else begin
      wr_en <= rec_ok;
      if (rec_ok) begin
        wr_state <= addr_q[4 +: STATE_WIDTH];
        wr_input <= addr_q[3:0];
        wr_next  <= next_q[STATE_WIDTH-1:0];
        wr_out   <= out_q;
      end
    end
  end

  // Sticky status. A fresh prog_enable session starts with clean status.
  always_ff @(posedge clock) begin
    if (rst) begin
      prev_enable <= 1'b0;
      err_chk     <= 1'b0;
      err_range   <= 1'b0;
      rec_count   <= '0;
`ifdef FSM_LOADER_TIMEOUT_EN
      err_timeout <= 1'b0;
`endif
    end else begin
      prev_enable <= prog_enable;
      if (enable_rise) begin
        err_chk     <= 1'b0;
        err_range   <= 1'b0;
        rec_count   <= '0;
`ifdef FSM_LOADER_TIMEOUT_EN
        err_timeout <= 1'b0;
`endif
      end else begin
        if (rec_chk_bad)   err_chk   <= 1'b1;
        if (rec_range_bad) err_range <= 1'b1;
        if (rec_ok)        rec_count <= rec_count + 8'd1;
`ifdef FSM_LOADER_TIMEOUT_EN
        if (timeout_hit)   err_timeout <= 1'b1;
`endif
      end
    end
  end

endmodule
